player_receptor_bar: RTL and testbench

//   Parametrised receptor bar for the DDR playfield. Draws NUM_LANES outlined

---
 rtl/player_receptor_bar_pkg.sv | 25 ++
 rtl/player_receptor_bar_if.sv | 22 ++
 rtl/player_receptor_bar_lane_receptor_fsm.sv | 80 ++++++++
 rtl/player_receptor_bar.sv | 89 ++++++++
 tb/tb_player_receptor_bar.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/player_receptor_bar_pkg.sv
// Shared playfield geometry defaults and lane FSM encodings for the receptor bar.
package player_receptor_bar_pkg;

    localparam logic [9:0] LANE0_X_DEF     = 10'd200;
    localparam logic [9:0] LANE_PITCH_DEF  = 10'd60;
    localparam logic [9:0] PLAYER_Y_DEF    = 10'd400;
    localparam logic [9:0] NOTE_WIDTH_DEF  = 10'd48;
    localparam logic [9:0] NOTE_HEIGHT_DEF = 10'd48;
    localparam logic [9:0] LINE_WIDTH_DEF  = 10'd3;
    localparam logic [9:0] LINE_HEIGHT_DEF = 10'd3;
    localparam int         X_LIMIT         = 640;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2,
        DECAY   = 2'd3
    } lane_state_t;

    function automatic logic [9:0] lane_x0(input int lane, input logic [9:0] x_base,
                                           input logic [9:0] pitch);
        return 10'(int'(x_base) + lane * int'(pitch));
    endfunction

endpackage

// File: rtl/player_receptor_bar_if.sv
// Button and pixel-bus bundle between the raw inputs / VGA mux and the receptor bar.
interface player_receptor_bar_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0] btn;
    logic [9:0]           x;
    logic [9:0]           y;
    logic                 is_player_bar;
    logic [2:0]           pix_lane;
    logic [NUM_LANES-1:0] press_pulse;
    logic [NUM_LANES-1:0] lane_lit;

    modport master (
        output btn, x, y,
        input  is_player_bar, pix_lane, press_pulse, lane_lit
    );

    modport slave (
        input  btn, x, y,
        output is_player_bar, pix_lane, press_pulse, lane_lit
    );
endinterface

// File: rtl/player_receptor_bar_lane_receptor_fsm.sv
// One receptor lane: 2-FF synchroniser, debouncer, press/hold/decay FSM.
//   state   | meaning
//   IDLE    | lane dark, waiting for a debounced press
//   PRESSED | single cycle after the press; drives press_pulse
//   HELD    | button still down, lane lit
//   DECAY   | released, lane kept lit until the decay counter expires
module player_receptor_bar_lane_receptor_fsm
    import player_receptor_bar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DECAY_CYCLES    = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_pulse,
    output logic lane_lit
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DEC_W = $clog2(DECAY_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEC_W-1:0] DEC_LOAD = DEC_W'(DECAY_CYCLES - 1);

    logic [1:0]       sync;
    logic             deb;
    logic [DEB_W-1:0] deb_cnt;
    lane_state_t      state;
    logic [DEC_W-1:0] dec_cnt;

    // deb follows sync only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync <= {sync[0], btn};
            if (sync[1] != deb) begin
                if (deb_cnt == DEB_LAST) begin
                    deb     <= sync[1];
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dec_cnt     <= '0;
            press_pulse <= 1'b0;
            lane_lit    <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (deb) state <= PRESSED;
                PRESSED: state <= HELD;
                HELD: begin
                    if (!deb) begin
                        state   <= DECAY;
                        dec_cnt <= DEC_LOAD;
                    end
                end
                DECAY: begin
                    if (deb)                 state   <= PRESSED;
                    else if (dec_cnt == '0)  state   <= IDLE;
                    else                     dec_cnt <= dec_cnt - DEC_W'(1);
                end
                default: state <= IDLE;
            endcase
            press_pulse <= (state == PRESSED);
            lane_lit    <= (state != IDLE);
        end
    end

endmodule

// File: rtl/player_receptor_bar.sv
// Receptor bar top: per-lane FSM instances plus the registered pixel hit test
// feeding the VGA pixel mux.
module player_receptor_bar
    import player_receptor_bar_pkg::*;
#(
    parameter int         NUM_LANES       = 4,
    parameter logic [9:0] LANE0_X         = LANE0_X_DEF,
    parameter logic [9:0] LANE_PITCH      = LANE_PITCH_DEF,
    parameter logic [9:0] PLAYER_Y        = PLAYER_Y_DEF,
    parameter logic [9:0] NOTE_WIDTH      = NOTE_WIDTH_DEF,
    parameter logic [9:0] NOTE_HEIGHT     = NOTE_HEIGHT_DEF,
    parameter logic [9:0] LINE_WIDTH      = LINE_WIDTH_DEF,
    parameter logic [9:0] LINE_HEIGHT     = LINE_HEIGHT_DEF,
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter int         DECAY_CYCLES    = 25000000
) (
    input logic            clk,
    input logic            rst,
    player_receptor_bar_if.slave bus
);

    if (NUM_LANES < 1 || NUM_LANES > 8) begin : g_bad_lanes
        $error("player_receptor_bar: NUM_LANES must be 1..8");
    end
    if (LANE_PITCH <= NOTE_WIDTH) begin : g_bad_pitch
        $error("player_receptor_bar: LANE_PITCH must exceed NOTE_WIDTH");
    end
    if (int'(LANE0_X) + (NUM_LANES - 1) * int'(LANE_PITCH) + int'(NOTE_WIDTH) >= X_LIMIT)
    begin : g_bad_span
        $error("player_receptor_bar: rightmost lane edge must be below 640");
    end

    logic [NUM_LANES-1:0] lit;
    logic [NUM_LANES-1:0] pulse;
    logic [NUM_LANES-1:0] hit;
    logic [2:0]           hit_lane;

    localparam logic [9:0] Y_BOT    = PLAYER_Y + NOTE_HEIGHT;
    localparam logic [9:0] Y_IN_TOP = PLAYER_Y + LINE_HEIGHT;
    localparam logic [9:0] Y_IN_BOT = PLAYER_Y + NOTE_HEIGHT - LINE_HEIGHT;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [9:0] X0      = lane_x0(i, LANE0_X, LANE_PITCH);
        localparam logic [9:0] X1      = X0 + NOTE_WIDTH;
        localparam logic [9:0] X_IN_L  = X0 + LINE_WIDTH;
        localparam logic [9:0] X_IN_R  = X0 + NOTE_WIDTH - LINE_WIDTH;
        logic outer;
        logic inner;

        player_receptor_bar_lane_receptor_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DECAY_CYCLES    (DECAY_CYCLES)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .btn         (bus.btn[i]),
            .press_pulse (pulse[i]),
            .lane_lit    (lit[i])
        );

        assign outer  = (bus.y >= PLAYER_Y) && (bus.y <= Y_BOT)
                     && (bus.x >= X0) && (bus.x <= X1);
        assign inner  = (bus.y >= Y_IN_TOP) && (bus.y <= Y_IN_BOT)
                     && (bus.x >= X_IN_L) && (bus.x <= X_IN_R);
        assign hit[i] = outer && (!inner || lit[i]);
    end

    // lanes never overlap, so at most one hit bit is set
    always_comb begin
        hit_lane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (hit[i]) hit_lane = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.is_player_bar <= 1'b0;
            bus.pix_lane      <= '0;
        end else begin
            bus.is_player_bar <= |hit;
            bus.pix_lane      <= hit_lane;
        end
    end

    assign bus.press_pulse = pulse;
    assign bus.lane_lit    = lit;

endmodule

// File: tb/tb_player_receptor_bar.sv
// Scoreboard bench for player_receptor_bar with short debounce/decay times.
module tb_player_receptor_bar;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic probe = 1'b0;

    typedef struct packed {
        logic       bar;
        logic [2:0] lane;
        logic [9:0] x;
        logic [9:0] y;
    } px_exp_t;

    typedef struct packed {
        int         cyc;
        logic [3:0] val;
    } pulse_exp_t;

    px_exp_t    pix_q[$];
    pulse_exp_t pulse_q[$];

    player_receptor_bar_if #(.NUM_LANES(4)) bus ();

    player_receptor_bar #(
        .NUM_LANES       (4),
        .DEBOUNCE_CYCLES (4),
        .DECAY_CYCLES    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic probe_px(input int px, input int py, input logic bar, input int lane);
        bus.x = 10'(px);
        bus.y = 10'(py);
        pix_q.push_back('{bar, 3'(lane), 10'(px), 10'(py)});
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;
    endtask

    task automatic expect_pulse(input int at, input logic [3:0] val);
        pulse_q.push_back('{at, val});
    endtask

    // pixel monitor: a probe driven before a rising edge is judged after it
    initial begin
        logic    pend;
        px_exp_t e;
        forever begin
            @(posedge clk);
            pend = probe;
            @(negedge clk);
            if (pend) begin
                if (pix_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_queue actual=empty required=entry cycle=%0d", cyc);
                end else begin
                    e = pix_q.pop_front();
                    check($sformatf("is_player_bar(%0d,%0d)", e.x, e.y),
                          int'(bus.is_player_bar), int'(e.bar));
                    check($sformatf("pix_lane(%0d,%0d)", e.x, e.y),
                          int'(bus.pix_lane), int'(e.lane));
                end
            end
        end
    end

    // pulse monitor: each expected pulse must appear on exactly its cycle
    initial begin
        pulse_exp_t p;
        forever begin
            @(negedge clk);
            if (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL press_pulse_missing actual=none required=%b expected_cycle=%0d",
                         pulse_q[0].val, pulse_q[0].cyc);
                pulse_q.delete(0);
            end
            if (bus.press_pulse != 4'b0000) begin
                if (pulse_q.size() > 0 && pulse_q[0].cyc == cyc) begin
                    p = pulse_q.pop_front();
                    check("press_pulse", int'(bus.press_pulse), int'(p.val));
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL press_pulse_unexpected actual=%b required=0000 cycle=%0d",
                             bus.press_pulse, cyc);
                end
            end
        end
    end

    px_exp_t sweep[20];

    initial begin
        bit exp_bar;

        sweep = '{
            '{1'b1, 3'd0, 10'd200, 10'd400}, '{1'b1, 3'd0, 10'd248, 10'd448},
            '{1'b0, 3'd0, 10'd224, 10'd424}, '{1'b0, 3'd0, 10'd249, 10'd400},
            '{1'b1, 3'd0, 10'd202, 10'd424}, '{1'b0, 3'd0, 10'd203, 10'd424},
            '{1'b1, 3'd0, 10'd246, 10'd424}, '{1'b1, 3'd0, 10'd224, 10'd446},
            '{1'b0, 3'd0, 10'd224, 10'd445}, '{1'b1, 3'd1, 10'd260, 10'd400},
            '{1'b1, 3'd1, 10'd308, 10'd448}, '{1'b0, 3'd0, 10'd284, 10'd424},
            '{1'b1, 3'd2, 10'd320, 10'd401}, '{1'b1, 3'd2, 10'd368, 10'd420},
            '{1'b1, 3'd3, 10'd380, 10'd400}, '{1'b1, 3'd3, 10'd428, 10'd448},
            '{1'b0, 3'd0, 10'd404, 10'd424}, '{1'b0, 3'd0, 10'd429, 10'd420},
            '{1'b0, 3'd0, 10'd300, 10'd399}, '{1'b0, 3'd0, 10'd300, 10'd449}
        };

        bus.btn = 4'b0000;
        bus.x   = 10'd0;
        bus.y   = 10'd0;
        #1 rst = 1'b1;

        at_cyc(1);
        check("reset_is_player_bar", int'(bus.is_player_bar), 0);
        check("reset_pix_lane",      int'(bus.pix_lane),      0);
        check("reset_press_pulse",   int'(bus.press_pulse),   0);
        check("reset_lane_lit",      int'(bus.lane_lit),      0);
        at_cyc(2);
        rst = 1'b0;

        // single-cycle glitch on lane 0 must be rejected by the debouncer
        at_cyc(4);
        bus.btn[0] = 1'b1;
        at_cyc(5);
        bus.btn[0] = 1'b0;
        at_cyc(15);
        check("glitch_lane_lit0", int'(bus.lane_lit[0]), 0);
        probe_px(224, 424, 1'b0, 0);

        // lane 1: first sampled at edge 30 -> pulse after edge 37;
        // released at edge 42 -> deb low after 47, DECAY 48..55, IDLE at 56,
        // lane_lit low after 57, inner pixel dark from observation 58
        at_cyc(29);
        bus.btn[1] = 1'b1;
        expect_pulse(37, 4'b0010);
        for (int c = 35; c <= 60; c++) begin
            at_cyc(c);
            if (c == 41) bus.btn[1] = 1'b0;
            exp_bar = (c + 1 >= 38) && (c + 1 <= 57);
            probe_px(284, 424, exp_bar, exp_bar ? 1 : 0);
        end

        // lane 3: press, release, re-press during DECAY -> second pulse, no dark gap
        at_cyc(79);
        bus.btn[3] = 1'b1;
        expect_pulse(87, 4'b1000);
        for (int c = 85; c <= 115; c++) begin
            at_cyc(c);
            if (c == 91) bus.btn[3] = 1'b0;
            if (c == 97) begin
                bus.btn[3] = 1'b1;
                expect_pulse(105, 4'b1000);
            end
            exp_bar = (c + 1 >= 88);
            probe_px(404, 424, exp_bar, exp_bar ? 3 : 0);
        end
        at_cyc(116);
        bus.btn[3] = 1'b0;

        // all lanes together
        at_cyc(149);
        bus.btn = 4'b1111;
        expect_pulse(157, 4'b1111);
        at_cyc(160);
        probe_px(344, 424, 1'b1, 2);

        // asynchronous reset mid-frame with lane 2 lit
        at_cyc(162);
        #2;
        rst = 1'b1;
        bus.btn = 4'b0000;
        #1;
        check("async_rst_lane_lit",      int'(bus.lane_lit),      0);
        check("async_rst_is_player_bar", int'(bus.is_player_bar), 0);
        check("async_rst_press_pulse",   int'(bus.press_pulse),   0);
        at_cyc(164);
        rst = 1'b0;
        probe_px(200, 400, 1'b1, 0);

        // idle sweep: borders only, gaps and interiors dark
        at_cyc(170);
        foreach (sweep[i]) begin
            probe_px(int'(sweep[i].x), int'(sweep[i].y), sweep[i].bar, int'(sweep[i].lane));
        end

        at_cyc(220);
        check("pulse_queue_drained", pulse_q.size(), 0);
        check("pix_queue_drained",   pix_q.size(),   0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
